// File: rtl/pc_stack.sv
// pc_stack: program counter with a LIFO return-address stack.
// Supports increment, absolute jump, relative branch, call and return.
// A call on a full stack or a return on an empty stack is ignored and
// raises a sticky error flag. hlt freezes all architectural state.
module pc_stack #(
  parameter int                 WIDTH      = 8,
  parameter int                 DEPTH      = 4,
  parameter logic [WIDTH-1:0]   RESET_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          hlt,
  input  logic [2:0]                    op,
  input  logic                          taken,
  input  logic [WIDTH-1:0]              target,
  input  logic [WIDTH-1:0]              offset,
  input  logic                          clr_err,
  output logic [WIDTH-1:0]              pc,
  output logic [$clog2(DEPTH+1)-1:0]    stk_cnt,
  output logic                          stk_empty,
  output logic                          stk_full,
  output logic                          err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_INC  = 3'b000,
    OP_JMP  = 3'b001,
    OP_BRA  = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100
  } op_e;

  logic [WIDTH-1:0] stack_mem [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_next;
  logic [CNT_W-1:0] cnt_next;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;
  logic             push;
  logic             err_set;

  // Flags are decoded straight from the count register.
  assign stk_empty = (stk_cnt == '0);
  assign stk_full  = (stk_cnt == CNT_W'(DEPTH));

  // Next free slot sits at stk_cnt; the top of stack one below it.
  assign pc_inc   = pc + WIDTH'(1);
  assign push_idx = IDX_W'(stk_cnt);
  assign top_idx  = IDX_W'(stk_cnt - CNT_W'(1));

  // Decode the operation into next PC, next count, push and error-set.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
    pc_next  = pc;
    cnt_next = stk_cnt;
    push     = 1'b0;
    err_set  = 1'b0;
    case (op_e'(op))
      OP_INC:  pc_next = pc_inc;
      OP_JMP:  pc_next = target;
      OP_BRA:  pc_next = taken ? (pc + offset) : pc_inc;
      OP_CALL: begin
        if (stk_full) begin
          err_set = 1'b1;
        end else begin
          push     = 1'b1;
          cnt_next = stk_cnt + CNT_W'(1);
          pc_next  = target;
        end
      end
      OP_RET: begin
        if (stk_empty) begin
          err_set = 1'b1;
        end else begin
          cnt_next = stk_cnt - CNT_W'(1);
          pc_next  = stack_mem[top_idx];
        end
      end
      default: ;
    endcase
  end

  // Architectural state: PC, stack depth and sticky error; held under hlt.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
    if (!reset_n) begin
      pc      <= RESET_ADDR;
      stk_cnt <= '0;
      err     <= 1'b0;
    end else if (!hlt) begin
      pc      <= pc_next;
      stk_cnt <= cnt_next;
      err     <= err_set | (err & ~clr_err);
    end
  end

  // Return-address storage; a push writes pc + 1 into the next free slot.
  always_ff @(posedge clk) begin
    // NOTE: the stack array is not reset; slots at or above stk_cnt are never read, so reset only clears the count.
    if (push && !hlt) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack (WIDTH=8, DEPTH=4, RESET_ADDR=0).
// Stimulus pushes hand-computed expected state into a queue; a monitor
// pops and compares after each clock edge or on an explicit sample event.
module tb_pc_stack;

  localparam logic [2:0] INC  = 3'b000;
  localparam logic [2:0] JMP  = 3'b001;
  localparam logic [2:0] BRA  = 3'b010;
  localparam logic [2:0] CALL = 3'b011;
  localparam logic [2:0] RET  = 3'b100;
  localparam logic [2:0] NOP5 = 3'b101;
  localparam logic [2:0] NOP6 = 3'b110;
  localparam logic [2:0] NOP7 = 3'b111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       hlt;
  logic [2:0] op;
  logic       taken;
  logic [7:0] target;
  logic [7:0] offset;
  logic       clr_err;
  logic [7:0] pc;
  logic [2:0] stk_cnt;
  logic       stk_empty;
  logic       stk_full;
  logic       err;

  typedef struct {
    string       name;
    logic [13:0] vec;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  pc_stack #(.WIDTH(8), .DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hlt       (hlt),
    .op        (op),
    .taken     (taken),
    .target    (target),
    .offset    (offset),
    .clr_err   (clr_err),
    .pc        (pc),
    .stk_cnt   (stk_cnt),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Expected packed state {pc, cnt, empty, full, err}.
  function automatic logic [13:0] mk(input logic [7:0] p, input logic [2:0] c, input logic e);
    return {p, c, (c == 3'd0), (c == 3'd4), e};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h cnt=%0d empty=%b full=%b err=%b, expected pc=%h cnt=%0d empty=%b full=%b err=%b",
               name, act[13:6], act[5:3], act[2], act[1], act[0],
               exp[13:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: after each rising edge (or a sample request) compare all pending expectations.
  initial begin
    forever begin
      @(posedge clk or sample_ev);
      #1;
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, {pc, stk_cnt, stk_empty, stk_full, err}, e.vec);
      end
    end
  end

  // Drive one op now and record the state expected after the next edge.
  task automatic issue(input string name, input logic h, input logic [2:0] o, input logic tk,
                       input logic [7:0] tg, input logic [7:0] of, input logic ce,
                       input logic [7:0] ep, input logic [2:0] ec, input logic ee);
    exp_t e;
    hlt     = h;
    op      = o;
    taken   = tk;
    target  = tg;
    offset  = of;
    clr_err = ce;
    e.name  = name;
    e.vec   = mk(ep, ec, ee);
    exp_q.push_back(e);
  endtask

  task automatic step(input string name, input logic h, input logic [2:0] o, input logic tk,
                      input logic [7:0] tg, input logic [7:0] of, input logic ce,
                      input logic [7:0] ep, input logic [2:0] ec, input logic ee);
    @(negedge clk);
    issue(name, h, o, tk, tg, of, ce, ep, ec, ee);
  endtask

  // Request an immediate (edge-independent) comparison.
  task automatic sample_now(input string name, input logic [7:0] ep, input logic [2:0] ec, input logic ee);
    exp_t e;
    e.name = name;
    e.vec  = mk(ep, ec, ee);
    exp_q.push_back(e);
    ->sample_ev;
  endtask

  initial begin
    reset_n = 1'b0;
    hlt     = 1'b0;
    op      = NOP5;
    taken   = 1'b0;
    target  = 8'h00;
    offset  = 8'h00;
    clr_err = 1'b0;

    #7;
    sample_now("reset_state", 8'h00, 3'd0, 1'b0);

    // First edge after release executes the presented op.
    @(negedge clk);
    reset_n = 1'b1;
    issue("inc_1", 0, INC, 0, 8'h00, 8'h00, 0, 8'h01, 3'd0, 0);
    step("inc_2",      0, INC,  0, 8'h00, 8'h00, 0, 8'h02, 3'd0, 0);
    step("inc_3",      0, INC,  0, 8'h00, 8'h00, 0, 8'h03, 3'd0, 0);

    // Wrap of increment and backward relative branch.
    step("jmp_fe",     0, JMP,  0, 8'hFE, 8'h00, 0, 8'hFE, 3'd0, 0);
    step("inc_ff",     0, INC,  0, 8'h00, 8'h00, 0, 8'hFF, 3'd0, 0);
    step("inc_wrap",   0, INC,  0, 8'h00, 8'h00, 0, 8'h00, 3'd0, 0);
    step("bra_back",   0, BRA,  1, 8'h00, 8'hFC, 0, 8'hFC, 3'd0, 0);

    // Not-taken branch, jump, forward wrapping branch.
    step("jmp_10",     0, JMP,  0, 8'h10, 8'h00, 0, 8'h10, 3'd0, 0);
    step("bra_nt",     0, BRA,  0, 8'h00, 8'h55, 0, 8'h11, 3'd0, 0);
    step("jmp_40",     0, JMP,  0, 8'h40, 8'h00, 0, 8'h40, 3'd0, 0);
    step("jmp_f0",     0, JMP,  0, 8'hF0, 8'h00, 0, 8'hF0, 3'd0, 0);
    step("bra_fwd",    0, BRA,  1, 8'h00, 8'h20, 0, 8'h10, 3'd0, 0);

    // Reserved encodings hold everything.
    step("nop5",       0, NOP5, 1, 8'h99, 8'h33, 0, 8'h10, 3'd0, 0);
    step("nop6",       0, NOP6, 1, 8'h99, 8'h33, 0, 8'h10, 3'd0, 0);
    step("nop7",       0, NOP7, 1, 8'h99, 8'h33, 0, 8'h10, 3'd0, 0);

    // Fill the stack, overflow, then unwind in LIFO order.
    step("jmp_05",     0, JMP,  0, 8'h05, 8'h00, 0, 8'h05, 3'd0, 0);
    step("call_20",    0, CALL, 0, 8'h20, 8'h00, 0, 8'h20, 3'd1, 0);
    step("call_30",    0, CALL, 0, 8'h30, 8'h00, 0, 8'h30, 3'd2, 0);
    step("call_40",    0, CALL, 0, 8'h40, 8'h00, 0, 8'h40, 3'd3, 0);
    step("call_50",    0, CALL, 0, 8'h50, 8'h00, 0, 8'h50, 3'd4, 0);
    step("call_ovf",   0, CALL, 0, 8'h60, 8'h00, 0, 8'h50, 3'd4, 1);
    step("err_sticky", 0, NOP5, 0, 8'h00, 8'h00, 0, 8'h50, 3'd4, 1);
    step("clr_ovf",    0, NOP5, 0, 8'h00, 8'h00, 1, 8'h50, 3'd4, 0);
    step("ret_41",     0, RET,  0, 8'h00, 8'h00, 0, 8'h41, 3'd3, 0);
    step("ret_31",     0, RET,  0, 8'h00, 8'h00, 0, 8'h31, 3'd2, 0);
    step("ret_21",     0, RET,  0, 8'h00, 8'h00, 0, 8'h21, 3'd1, 0);
    step("ret_06",     0, RET,  0, 8'h00, 8'h00, 0, 8'h06, 3'd0, 0);

    // Underflow, hold of err under hlt, clear, set-wins-over-clear.
    step("ret_udf",    0, RET,  0, 8'h00, 8'h00, 0, 8'h06, 3'd0, 1);
    step("hlt_clr",    1, INC,  0, 8'h00, 8'h00, 1, 8'h06, 3'd0, 1);
    step("clr_udf",    0, NOP5, 0, 8'h00, 8'h00, 1, 8'h06, 3'd0, 0);
    step("udf_and_clr",0, RET,  0, 8'h00, 8'h00, 1, 8'h06, 3'd0, 1);
    step("clr_again",  0, NOP5, 0, 8'h00, 8'h00, 1, 8'h06, 3'd0, 0);

    // hlt freezes calls/returns and stack contents survive.
    step("jmp_70",     0, JMP,  0, 8'h70, 8'h00, 0, 8'h70, 3'd0, 0);
    step("call_80",    0, CALL, 0, 8'h80, 8'h00, 0, 8'h80, 3'd1, 0);
    step("call_90",    0, CALL, 0, 8'h90, 8'h00, 0, 8'h90, 3'd2, 0);
    step("hlt_call",   1, CALL, 0, 8'hA0, 8'h00, 0, 8'h90, 3'd2, 0);
    step("hlt_ret",    1, RET,  0, 8'h00, 8'h00, 0, 8'h90, 3'd2, 0);
    step("ret_81",     0, RET,  0, 8'h00, 8'h00, 0, 8'h81, 3'd1, 0);
    step("call_90b",   0, CALL, 0, 8'h90, 8'h00, 0, 8'h90, 3'd2, 0);

    // Asynchronous reset between edges with two entries stacked.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    sample_now("async_reset", 8'h00, 3'd0, 1'b0);
    step("reset_hold", 0, CALL, 0, 8'hA0, 8'h00, 0, 8'h00, 3'd0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    issue("post_rst_inc", 0, INC, 0, 8'h00, 8'h00, 0, 8'h01, 3'd0, 0);
    step("post_rst_ret", 0, RET,  0, 8'h00, 8'h00, 0, 8'h01, 3'd0, 1);
    step("final_nop",    0, NOP5, 0, 8'h00, 8'h00, 0, 8'h01, 3'd0, 1);

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 8: program-counter and address width in bits.
REQ-002 Parameter DEPTH, default 4: return-address stack entries (1 or more).
REQ-003 Parameter RESET_ADDR, default 0: PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 hlt  input  1  high: freeze PC, stack and flags.
REQ-007 op  input  3  operation select (encodings in Function).
REQ-008 taken  input  1  branch condition for BRA.
REQ-009 target  input  WIDTH  absolute address for JMP and CALL.
REQ-010 offset  input  WIDTH  two's-complement relative displacement for BRA.
REQ-011 clr_err  input  1  synchronous clear of err.
REQ-012 pc  output  WIDTH  registered program counter.
REQ-013 stk_cnt  output  $clog2(DEPTH+1)  current number of stacked return addresses.
REQ-014 stk_empty  output  1  high when stk_cnt == 0.
REQ-015 stk_full  output  1  high when stk_cnt == DEPTH.
REQ-016 err  output  1  sticky flag for stack overflow or underflow.

Function
REQ-017 Every output shall be registered or decoded from registers only; a single-cycle op takes effect at the next rising edge (latency 1).
REQ-018 op 000 INC shall set pc <= pc + 1.
REQ-019 op 001 JMP shall set pc <= target.
REQ-020 op 010 BRA shall set pc <= pc + offset when taken = 1, otherwise pc <= pc + 1.
REQ-021 op 011 CALL shall push pc + 1 onto the stack, increment stk_cnt and set pc <= target.
REQ-022 op 100 RET shall pop the top entry into pc and decrement stk_cnt.
REQ-023 op 101, 110 and 111 shall be NOP: pc, stack and stk_cnt hold.
REQ-024 All PC arithmetic shall be modulo 2^WIDTH: pc + 1 at all-ones wraps to 0, and pc + offset wraps in both directions.
REQ-025 The stack shall be LIFO: RET returns the most recently pushed, not yet popped, address.
REQ-026 CALL while stk_full = 1 shall leave pc, stack and stk_cnt unchanged and set err.
REQ-027 RET while stk_empty = 1 shall leave pc and stk_cnt unchanged and set err.
REQ-028 err shall stay high until reset or until a cycle with clr_err = 1.
REQ-029 If clr_err = 1 and a new overflow or underflow occur in the same cycle, err shall be 1 (the set wins).
REQ-030 hlt = 1 shall hold pc, stack contents, stk_cnt and err regardless of op or clr_err.
REQ-031 Stack entries at or above stk_cnt are don't-care and shall never reach pc.

Reset
REQ-032 reset_n = 0 shall immediately, independent of clk, force pc = RESET_ADDR, stk_cnt = 0, stk_empty = 1, stk_full = 0 and err = 0.
REQ-033 Asserting reset_n mid-operation shall discard pending stack contents; stack storage itself needs no reset.
REQ-034 On the first rising edge after reset_n deasserts, the block shall execute the op presented at that edge normally.

Verification
REQ-035 Reset, then 3 cycles of INC (WIDTH=8) -> pc 00, 01, 02, 03.
REQ-036 pc = FE, INC twice; then BRA with offset FC, taken = 1, from pc 00 -> pc FF, 00, then FC.
REQ-037 pc = 10, BRA with taken = 0 -> pc 11; JMP target 40 -> pc 40.
REQ-038 DEPTH=4: CALL 20, 30, 40, 50 from pc 05 -> stk_full = 1 and stk_cnt = 4; a fifth CALL 60 leaves pc = 50 and sets err; four RETs give pc 41, 31, 21, 06 in that order, then stk_empty = 1.
REQ-039 RET with an empty stack -> pc unchanged, err = 1; clr_err pulse -> err = 0; RET on empty together with clr_err -> err = 1.
REQ-040 hlt = 1 during CALL -> no change; reset_n pulsed low between clock edges with stk_cnt = 2 -> pc = RESET_ADDR, stk_cnt = 0 immediately, without waiting for an edge.
